// File: rtl/divider_pkg.sv
// Shared definitions for the divider operand registers: op encodings and FSM states.
package divider_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/divider_op_reg_if.sv
// Command/status bundle between the divider controller (master) and an operand register (slave).
interface divider_op_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic [2:0]       op;
    logic [WIDTH-1:0] D;
    logic             sin;
    logic             start;
    logic [CNT_W-1:0] nshift;
    logic [WIDTH-1:0] Q;
    logic             zFlag;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output op, D, sin, start, nshift,
        input  Q, zFlag, cout, busy, done
    );

    modport slave (
        input  op, D, sin, start, nshift,
        output Q, zFlag, cout, busy, done
    );
endinterface

// File: rtl/burst_counter.sv
// Down-counter holding the number of shifts still owed in a burst.
module burst_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);
    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/divider_op_reg.sv
// Multi-mode operand register (load/shift/inc/dec/clear) with a self-timed shift burst.
module divider_op_reg
    import divider_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    divider_op_reg_if.slave   bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_last;
    logic [WIDTH:0]   inc_sum;

    burst_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (bus.nshift),
        .last     (cnt_last)
    );

    assign inc_sum = {1'b0, q_q} + (WIDTH + 1)'(1);

    // NOTE: every variable gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // A burst request overrides any op presented in the same cycle.
                    cnt_load = 1'b1;
                    if (bus.nshift != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    case (bus.op)
                        OP_LOAD: begin
                            q_d    = bus.D;
                            cout_d = 1'b0;
                        end
                        OP_SHL: begin
                            q_d    = {q_q[WIDTH-2:0], bus.sin};
                            cout_d = q_q[WIDTH-1];
                        end
                        OP_SHR: begin
                            q_d    = {bus.sin, q_q[WIDTH-1:1]};
                            cout_d = q_q[0];
                        end
                        OP_INC: begin
                            q_d    = inc_sum[WIDTH-1:0];
                            cout_d = inc_sum[WIDTH];
                        end
                        OP_DEC: begin
                            q_d    = q_q - WIDTH'(1);
                            cout_d = (q_q == '0);
                        end
                        OP_CLR: begin
                            q_d    = '0;
                            cout_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                q_d     = {q_q[WIDTH-2:0], bus.sin};
                cout_d  = q_q[WIDTH-1];
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: only control/data flops live here; reset returns them all to idle values with no done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.zFlag = (q_q == '0);
    assign bus.cout  = cout_q;
    assign bus.busy  = (state_q == ST_SHIFT);
    assign bus.done  = done_q;
endmodule
